// File: rtl/mips_multicycle_if.sv
// Shared instruction/data memory port with a single-cycle ready handshake.
interface mips_multicycle_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core (lw/sw/R-type/addi/beq/j) on one shared memory port.
// Define MIPS_MC_BNE_EN to add bne; otherwise op 000101 decodes as a nop.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               reset,
    mips_multicycle_if.master  mem,
    output logic [31:0]        pc,
    output logic [3:0]         state,
    output logic               retired
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        take;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [31:0] simm;

    assign op    = ir_q[31:26];
    assign rs    = ir_q[25:21];
    assign rt    = ir_q[20:16];
    assign rd    = ir_q[15:11];
    assign funct = ir_q[5:0];
    assign simm  = {{16{ir_q[15]}}, ir_q[15:0]};

    assign mem.mem_req   = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                           (state_q == S_MEMWR);
    assign mem.mem_we    = (state_q == S_MEMWR);
    assign mem.mem_addr  = (state_q == S_FETCH) ? pc_q : alu_q;
    assign mem.mem_wdata = b_q;

    assign pc    = pc_q;
    assign state = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        rf_we   = 1'b0;
        rf_wa   = rt;
        rf_wd   = alu_q;
        retired = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (mem.mem_ready) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rf_q[rs];
                b_d   = rf_q[rt];
                alu_d = pc_q + (simm << 2);
                case (op)
                    6'b100011,
                    6'b101011: state_d = S_MEMADR;
                    6'b000000: state_d = S_EXECUTE;
                    6'b000100: state_d = S_BRANCH;
`ifdef MIPS_MC_BNE_EN
                    6'b000101: state_d = S_BRANCH;
`endif
                    6'b001000: state_d = S_ADDIEX;
                    6'b000010: state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        retired = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_d   = a_q + simm;
                state_d = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem.mem_ready) begin
                    mdr_d   = mem.mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wd   = mdr_q;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem.mem_ready) begin
                    retired = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_d = S_ALUWB;
                case (funct)
                    6'b100000: alu_d = a_q + b_q;
                    6'b100010: alu_d = a_q - b_q;
                    6'b100100: alu_d = a_q & b_q;
                    6'b100101: alu_d = a_q | b_q;
                    6'b101010: alu_d = {31'b0, $signed(a_q) < $signed(b_q)};
                    default:   state_d = S_FETCH;
                endcase
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                take = (a_q == b_q);
`ifdef MIPS_MC_BNE_EN
                if (op == 6'b000101) take = (a_q != b_q);
`endif
                if (take) pc_d = alu_q;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = a_q + simm;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                retired = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                retired = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // r0 is never written, so it always reads back as zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            mdr_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
        end
    end
endmodule
